// File: rtl/secuenciador_motor.sv
// Motor drive sequencer: turns the stop/up/down command into brake timing,
// a soft-start/soft-stop speed ramp, reversal dead time and a door/emergency interlock.
module secuenciador_motor #(
   parameter int T_FRENO    = 50,
   parameter int T_MUERTO   = 100,
   parameter int RAMPA_PASO = 8,
   parameter int VEL_MAX    = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] motor_cmd,
   input  logic       puertas_cerradas,
   input  logic       emergencia,
   output logic       freno,
   output logic       dir,
   output logic [3:0] vel,
   output logic       en_movimiento,
   output logic       listo,
   output logic       falla,
   output logic [2:0] estado_dbg
);

   localparam int T_MAX_A = (T_FRENO > T_MUERTO) ? T_FRENO : T_MUERTO;
   localparam int T_MAX   = (T_MAX_A > RAMPA_PASO) ? T_MAX_A : RAMPA_PASO;
   localparam int TW      = (T_MAX < 2) ? 1 : $clog2(T_MAX);

   typedef enum logic [2:0] {
      REPOSO, SOLTAR_FRENO, ACELERAR, CRUCERO,
      DECELERAR, APLICAR_FRENO, MUERTO, FALLA
   } estado_t;

   estado_t       estado_q, estado_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    vel_q, vel_d;
   logic          dir_q, dir_d;
   logic          freno_q, en_mov_q, listo_q, falla_q;
   logic          cmd_mover, cmd_dir, cmd_igual, en_marcha_q, en_marcha_d;
   logic          fin_freno, fin_muerto, fin_rampa;

   assign cmd_mover  = (motor_cmd == 2'b01) || (motor_cmd == 2'b10);
   assign cmd_dir    = (motor_cmd == 2'b01);
   assign cmd_igual  = cmd_mover && (cmd_dir == dir_q);
   assign fin_freno  = (timer_q == TW'(T_FRENO - 1));
   assign fin_muerto = (timer_q == TW'(T_MUERTO - 1));
   assign fin_rampa  = (timer_q == TW'(RAMPA_PASO - 1));

   assign en_marcha_q = (estado_q == SOLTAR_FRENO) || (estado_q == ACELERAR) ||
                        (estado_q == CRUCERO) || (estado_q == DECELERAR);
   assign en_marcha_d = (estado_d == SOLTAR_FRENO) || (estado_d == ACELERAR) ||
                        (estado_d == CRUCERO) || (estado_d == DECELERAR);

   always_comb begin
      estado_d = estado_q;
      vel_d    = vel_q;
      dir_d    = dir_q;
      timer_d  = timer_q + 1'b1;
      case (estado_q)
         REPOSO: begin
            vel_d   = '0;
            timer_d = '0;
            if (cmd_mover && puertas_cerradas) begin
               dir_d    = cmd_dir;
               estado_d = SOLTAR_FRENO;
            end
         end
         SOLTAR_FRENO: begin
            if (!cmd_igual)     estado_d = APLICAR_FRENO;
            else if (fin_freno) estado_d = ACELERAR;
         end
         ACELERAR: begin
            if (!cmd_igual) begin
               estado_d = DECELERAR;
            end else if (fin_rampa) begin
               timer_d = '0;
               if (vel_q >= 4'(VEL_MAX - 1)) begin
                  vel_d    = 4'(VEL_MAX);
                  estado_d = CRUCERO;
               end else begin
                  vel_d = vel_q + 4'd1;
               end
            end
         end
         CRUCERO: begin
            vel_d   = 4'(VEL_MAX);
            timer_d = '0;
            if (!cmd_igual) estado_d = DECELERAR;
         end
         DECELERAR: begin
            if (cmd_igual && (vel_q != 4'd0)) begin
               estado_d = ACELERAR;
            end else if (fin_rampa) begin
               timer_d = '0;
               if (vel_q <= 4'd1) begin
                  vel_d    = '0;
                  estado_d = APLICAR_FRENO;
               end else begin
                  vel_d = vel_q - 4'd1;
               end
            end
         end
         APLICAR_FRENO: begin
            vel_d = '0;
            if (fin_freno) estado_d = MUERTO;
         end
         MUERTO: begin
            vel_d = '0;
            if (fin_muerto) estado_d = REPOSO;
         end
         default: begin
            vel_d   = '0;
            timer_d = '0;
         end
      endcase
      // Interlock overrides whatever the sequencing above decided.
      if (emergencia || (!puertas_cerradas && en_marcha_q)) begin
         estado_d = FALLA;
         vel_d    = '0;
         dir_d    = dir_q;
      end
      if (estado_d != estado_q) timer_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= REPOSO;
         timer_q  <= '0;
         vel_q    <= '0;
         dir_q    <= 1'b0;
         freno_q  <= 1'b1;
         en_mov_q <= 1'b0;
         listo_q  <= 1'b1;
         falla_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         timer_q  <= timer_d;
         vel_q    <= vel_d;
         dir_q    <= dir_d;
         freno_q  <= !en_marcha_d;
         en_mov_q <= en_marcha_d;
         listo_q  <= (estado_d == REPOSO);
         falla_q  <= (estado_d == FALLA);
      end
   end

   assign freno         = freno_q;
   assign dir           = dir_q;
   assign vel           = vel_q;
   assign en_movimiento = en_mov_q;
   assign listo         = listo_q;
   assign falla         = falla_q;
   assign estado_dbg    = estado_q;

endmodule

// File: tb/tb_secuenciador_motor.sv
// Directed bench for secuenciador_motor with short timing parameters
// (T_FRENO=4, T_MUERTO=6, RAMPA_PASO=2, VEL_MAX=3).
module tb_secuenciador_motor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] motor_cmd = 2'b00;
   logic       puertas_cerradas = 1'b1;
   logic       emergencia = 1'b0;
   logic       freno, dir, en_movimiento, listo, falla;
   logic [3:0] vel;
   logic [2:0] estado_dbg;

   int errors = 0;
   int checks = 0;

   secuenciador_motor #(
      .T_FRENO(4), .T_MUERTO(6), .RAMPA_PASO(2), .VEL_MAX(3)
   ) dut (
      .clk(clk), .rst(rst), .motor_cmd(motor_cmd),
      .puertas_cerradas(puertas_cerradas), .emergencia(emergencia),
      .freno(freno), .dir(dir), .vel(vel), .en_movimiento(en_movimiento),
      .listo(listo), .falla(falla), .estado_dbg(estado_dbg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; motor_cmd = 2'b00; puertas_cerradas = 1'b1; emergencia = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; motor_cmd = 2'b01; puertas_cerradas = 1'b1; emergencia = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (freno !== 1'b1) begin errors++; $display("FAIL reset_freno: got %b want 1", freno); end
         checks++; if (vel !== 4'd0) begin errors++; $display("FAIL reset_vel: got %0d want 0", vel); end
         checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b want 0", dir); end
         checks++; if (listo !== 1'b1) begin errors++; $display("FAIL reset_listo: got %b want 1", listo); end
         checks++; if (falla !== 1'b0) begin errors++; $display("FAIL reset_falla: got %b want 0", falla); end
         checks++; if (en_movimiento !== 1'b0) begin errors++; $display("FAIL reset_en_mov: got %b want 0", en_movimiento); end
      end
      motor_cmd = 2'b00;
      rst = 1'b0;
   endtask

   task automatic test_viaje_normal();
      do_reset();
      motor_cmd = 2'b01;
      step();
      checks++; if (freno !== 1'b0) begin errors++; $display("FAIL viaje_freno_suelto: got %b want 0", freno); end
      checks++; if (dir !== 1'b1) begin errors++; $display("FAIL viaje_dir: got %b want 1", dir); end
      checks++; if (en_movimiento !== 1'b1) begin errors++; $display("FAIL viaje_en_mov: got %b want 1", en_movimiento); end
      checks++; if (listo !== 1'b0) begin errors++; $display("FAIL viaje_listo: got %b want 0", listo); end
      for (int e = 2; e <= 11; e++) begin
         step();
         checks++;
         if (vel !== 4'((e < 5) ? 0 : (e - 5) / 2)) begin
            errors++; $display("FAIL viaje_rampa_sub e%0d: got %0d want %0d", e, vel, (e < 5) ? 0 : (e - 5) / 2);
         end
      end
      motor_cmd = 2'b00;
      for (int c = 1; c <= 7; c++) begin
         step();
         checks++;
         if (vel !== 4'(3 - (c - 1) / 2)) begin
            errors++; $display("FAIL viaje_rampa_baja c%0d: got %0d want %0d", c, vel, 3 - (c - 1) / 2);
         end
         checks++;
         if (freno !== ((c == 7) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL viaje_freno c%0d: got %b want %b", c, freno, (c == 7));
         end
      end
      // Doors opening while braking / in dead time must not fault.
      puertas_cerradas = 1'b0;
      for (int c = 8; c <= 16; c++) begin
         step();
         if (c == 14) puertas_cerradas = 1'b1;
         checks++; if (listo !== 1'b0) begin errors++; $display("FAIL viaje_listo_pronto c%0d: got %b want 0", c, listo); end
         checks++; if (falla !== 1'b0) begin errors++; $display("FAIL viaje_puertas_falla c%0d: got %b want 0", c, falla); end
         checks++; if (freno !== 1'b1) begin errors++; $display("FAIL viaje_freno_apl c%0d: got %b want 1", c, freno); end
      end
      step();
      checks++; if (listo !== 1'b1) begin errors++; $display("FAIL viaje_listo_final: got %b want 1", listo); end
   endtask

   task automatic test_puertas_abiertas();
      do_reset();
      motor_cmd = 2'b10; puertas_cerradas = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++; if (listo !== 1'b1) begin errors++; $display("FAIL puertas_listo %0d: got %b want 1", i, listo); end
         checks++; if (freno !== 1'b1) begin errors++; $display("FAIL puertas_freno %0d: got %b want 1", i, freno); end
         checks++; if (vel !== 4'd0) begin errors++; $display("FAIL puertas_vel %0d: got %0d want 0", i, vel); end
         checks++; if (falla !== 1'b0) begin errors++; $display("FAIL puertas_falla %0d: got %b want 0", i, falla); end
      end
      motor_cmd = 2'b00; puertas_cerradas = 1'b1;
   endtask

   task automatic test_inversion();
      logic       prev_dir, prev_freno;
      logic [3:0] prev_vel;
      do_reset();
      motor_cmd = 2'b01;
      repeat (11) step();
      checks++; if (vel !== 4'd3) begin errors++; $display("FAIL inv_crucero: got %0d want 3", vel); end
      motor_cmd = 2'b10;
      for (int c = 1; c <= 18; c++) begin
         prev_dir = dir; prev_freno = freno; prev_vel = vel;
         step();
         checks++;
         if ((dir !== prev_dir) && ((prev_freno !== 1'b1) || (prev_vel !== 4'd0))) begin
            errors++; $display("FAIL inv_dir_cambio c%0d: got freno=%b vel=%0d want freno=1 vel=0", c, prev_freno, prev_vel);
         end
         checks++;
         if (dir !== ((c <= 17) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL inv_dir c%0d: got %b want %b", c, dir, (c > 17) ? 1'b0 : 1'b1);
         end
      end
      checks++; if (freno !== 1'b0) begin errors++; $display("FAIL inv_arranque_freno: got %b want 0", freno); end
      checks++; if (en_movimiento !== 1'b1) begin errors++; $display("FAIL inv_arranque_mov: got %b want 1", en_movimiento); end
      repeat (6) step();
      checks++; if (vel !== 4'd1) begin errors++; $display("FAIL inv_bajada_vel: got %0d want 1", vel); end
      motor_cmd = 2'b00;
   endtask

   task automatic test_reacelerar();
      do_reset();
      motor_cmd = 2'b01;
      repeat (11) step();
      motor_cmd = 2'b00;
      for (int c = 1; c <= 9; c++) begin
         step();
         if (c == 3) motor_cmd = 2'b01;
         checks++;
         if (vel !== ((c == 1 || c == 2 || c > 5) ? 4'd3 : 4'd2)) begin
            errors++; $display("FAIL reacel_vel c%0d: got %0d want %0d", c, vel, (c == 1 || c == 2 || c > 5) ? 3 : 2);
         end
         checks++; if (freno !== 1'b0) begin errors++; $display("FAIL reacel_freno c%0d: got %b want 0", c, freno); end
      end
      motor_cmd = 2'b00;
   endtask

   task automatic test_emergencia();
      do_reset();
      motor_cmd = 2'b01;
      repeat (9) step();
      checks++; if (vel !== 4'd2) begin errors++; $display("FAIL emer_vel_previa: got %0d want 2", vel); end
      emergencia = 1'b1;
      step();
      emergencia = 1'b0;
      checks++; if (vel !== 4'd0) begin errors++; $display("FAIL emer_vel: got %0d want 0", vel); end
      checks++; if (freno !== 1'b1) begin errors++; $display("FAIL emer_freno: got %b want 1", freno); end
      checks++; if (falla !== 1'b1) begin errors++; $display("FAIL emer_falla: got %b want 1", falla); end
      checks++; if (en_movimiento !== 1'b0) begin errors++; $display("FAIL emer_mov: got %b want 0", en_movimiento); end
      checks++; if (listo !== 1'b0) begin errors++; $display("FAIL emer_listo: got %b want 0", listo); end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (falla !== 1'b1) begin errors++; $display("FAIL emer_pegada %0d: got %b want 1", i, falla); end
         checks++; if (freno !== 1'b1) begin errors++; $display("FAIL emer_freno_pegado %0d: got %b want 1", i, freno); end
      end
      rst = 1'b1;
      step();
      rst = 1'b0; motor_cmd = 2'b00;
      checks++; if (falla !== 1'b0) begin errors++; $display("FAIL emer_rst_falla: got %b want 0", falla); end
      checks++; if (listo !== 1'b1) begin errors++; $display("FAIL emer_rst_listo: got %b want 1", listo); end
   endtask

   task automatic test_puertas_en_marcha();
      do_reset();
      motor_cmd = 2'b01;
      repeat (3) step();
      puertas_cerradas = 1'b0;
      step();
      puertas_cerradas = 1'b1;
      checks++; if (falla !== 1'b1) begin errors++; $display("FAIL marcha_puertas_falla: got %b want 1", falla); end
      checks++; if (freno !== 1'b1) begin errors++; $display("FAIL marcha_puertas_freno: got %b want 1", freno); end
      motor_cmd = 2'b00;
   endtask

   initial begin
      test_reset();
      test_viaje_normal();
      test_puertas_abiertas();
      test_inversion();
      test_reacelerar();
      test_emergencia();
      test_puertas_en_marcha();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/secuenciador_motor.md
Name: secuenciador_motor

Overview:
Motor drive sequencer sitting directly downstream of the car-movement algorithm. Consumes its 2-bit motor command (stop/up/down) and turns it into safe drive signals: brake release/engage timing, soft-start/soft-stop speed ramp, dead time on direction reversal, and a door-closed/emergency interlock. Outputs go to the motor drive and brake actuator; status flags are returned to the control logic.

Parameters:
T_FRENO, 50, cycles allowed for brake release or engagement
T_MUERTO, 100, dead-time cycles after brake engage before any new start
RAMPA_PASO, 8, cycles per one-step speed change during ramps
VEL_MAX, 15, cruise speed code (fits in 4 bits, >=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
motor_cmd  in  2  01 = up, 10 = down, 00/11 = stop
puertas_cerradas  in  1  1 = doors fully closed and locked
emergencia  in  1  1 = emergency stop request
freno  out  1  1 = brake engaged
dir  out  1  1 = up, 0 = down; only changes while vel==0 and freno==1
vel  out  4  speed code to drive, 0..VEL_MAX
en_movimiento  out  1  1 in SOLTAR_FRENO, ACELERAR, CRUCERO, DECELERAR
listo  out  1  1 only in REPOSO
falla  out  1  sticky fault flag, cleared only by rst

Behaviour:
- All outputs registered. Inputs sampled at edge N; resulting state and outputs visible after edge N+1.
- Reset (rst=1 at an edge, including mid-operation): state REPOSO, freno=1, vel=0, dir=0, en_movimiento=0, listo=1, falla=0, counters=0.
- One shared timer. It is wide enough for max(T_FRENO, T_MUERTO, RAMPA_PASO) and is reloaded on every state entry.
- A "move" command is 01 or 10. A "same" command equals the latched dir. "Stop/opposite" means 00, 11, or the other direction.
- REPOSO: freno=1, vel=0.
  - On a move command with puertas_cerradas=1: latch dir from the command, go to SOLTAR_FRENO.
  - On a move command with doors open: stay in REPOSO.
- SOLTAR_FRENO: freno=0, vel=0.
  - After T_FRENO cycles: go to ACELERAR.
  - On a stop/opposite command: go to APLICAR_FRENO.
- ACELERAR: every RAMPA_PASO cycles, vel+1.
  - The step that reaches VEL_MAX enters CRUCERO.
  - On a stop/opposite command: go to DECELERAR; vel holds and the step timer restarts.
- CRUCERO: vel=VEL_MAX. On a stop/opposite command: go to DECELERAR.
- DECELERAR: every RAMPA_PASO cycles, vel-1.
  - The step that reaches 0 enters APLICAR_FRENO.
  - On a same command while vel>0: return to ACELERAR from the current vel, without braking.
- APLICAR_FRENO: freno=1, vel=0. After T_FRENO cycles: go to MUERTO. Commands are ignored.
- MUERTO: freno=1. After T_MUERTO cycles: go to REPOSO. Commands are ignored.
  - A pending reversal is then handled by normal REPOSO start logic; this is the only path for a dir change.
- Interlock: emergencia=1 in any state, or puertas_cerradas=0 in SOLTAR_FRENO, ACELERAR, CRUCERO or DECELERAR:
  - Next edge enters FALLA: vel=0, freno=1, falla=1, en_movimiento=0, listo=0.
  - FALLA is absorbing until rst.
  - The interlock takes priority over all other transitions in the same cycle.
- Doors opening in REPOSO, APLICAR_FRENO or MUERTO is not a fault.
- vel never wraps: no increment at VEL_MAX, no decrement at 0.

Test Plan:
Use parameters T_FRENO=4, T_MUERTO=6, RAMPA_PASO=2, VEL_MAX=3 unless stated.
1. Reset: assert rst 2 cycles with cmd=01 and doors closed -> freno=1, vel=0, dir=0, listo=1, falla=0, en_movimiento=0; no start while rst=1.
2. Normal trip: cmd=01, doors closed -> freno=0 and dir=1 one cycle later; vel 1,2,3 at 2-cycle intervals after the 4-cycle release. Then cmd=00 -> vel 2,1,0 at 2-cycle intervals; freno=1; listo=1 after 4+6 further cycles.
3. Doors open: cmd=10 with puertas_cerradas=0 for 20 cycles -> remains REPOSO, freno=1, vel=0, falla=0.
4. Reversal: cruising up at vel=3, cmd=10 -> ramp to 0, brake, dead time; dir changes to 0 only while freno=1 and vel=0; a down trip then starts automatically.
5. Re-accelerate: at vel=2 during decel, cmd returns to 01 -> vel rises 2->3; freno stays 0 throughout.
6. Emergency: emergencia=1 for one cycle at vel=2 -> next cycle vel=0, freno=1, falla=1; falla stays 1 and cmd=01 is ignored until rst.
